// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

    localparam int unsigned BYTE_WIDTH  = 8;
    localparam int unsigned COUNT_WIDTH = 16;

    // Frame start marker used when the instantiating wrapper does not override it.
    localparam logic [BYTE_WIDTH-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Words arrive MSB first: high byte, then low byte.
    localparam int unsigned WORD_HI_LSB = 8;
    localparam int unsigned WORD_LO_LSB = 0;

    typedef enum logic [3:0] {
        StIdle,
        StCntHi,
        StCntLo,
        StDataHi,
        StDataLo,
        StWrite,
        StCheck,
        StDone,
        StError
    } loader_state_t;

    // A word count is usable when it is non-zero and fits the program RAM.
    function automatic logic count_valid(input logic [COUNT_WIDTH-1:0] n,
                                         input int unsigned addr_width);
        logic [COUNT_WIDTH:0] limit;
        limit = (COUNT_WIDTH + 1)'(1) << addr_width;
        return (n != '0) && ({1'b0, n} <= limit);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and program RAM write port of the loader, plus core control status.
interface program_loader_if
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 16
);

    logic [BYTE_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  prog_write;
    logic [ADDR_WIDTH-1:0] prog_address;
    logic [DATA_WIDTH-1:0] prog_data;
    logic                  cpu_hold;
    logic                  load_done;
    logic                  load_error;

    // Loader side.
    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output prog_write,
        output prog_address,
        output prog_data,
        output cpu_hold,
        output load_done,
        output load_error
    );

    // Byte source / RAM / core side.
    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  prog_write,
        input  prog_address,
        input  prog_data,
        input  cpu_hold,
        input  load_done,
        input  load_error
    );

endinterface

// File: rtl/program_loader.sv
// Byte-stream loader: parses SYNC/count/words/checksum frames and writes the program RAM,
// holding the core stopped while an image is being loaded or after a rejected frame.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH        = 12,
    parameter int unsigned           INSTRUCTION_WIDTH = 4,
    parameter int unsigned           DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH,
    parameter logic [BYTE_WIDTH-1:0] SYNC_BYTE         = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    program_loader_if.master  bus
);

    if (DATA_WIDTH != 16 || DATA_WIDTH != ADDR_WIDTH + INSTRUCTION_WIDTH) begin : g_width_check
        $error("program_loader: DATA_WIDTH must be 16 and equal ADDR_WIDTH+INSTRUCTION_WIDTH");
    end

    loader_state_t          state_q, state_d;
    logic                   run_q;
    logic [ADDR_WIDTH:0]    addr_q, addr_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [BYTE_WIDTH-1:0]  chk_q, chk_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;

    logic                   ready;
    logic                   accept;
    logic                   is_sync;
    logic                   last_word;
    logic [COUNT_WIDTH-1:0] count_full;

    assign accept     = bus.rx_valid & ready;
    assign is_sync    = (bus.rx_data == SYNC_BYTE);
    assign count_full = {count_q[COUNT_WIDTH-1:BYTE_WIDTH], bus.rx_data};
    // Counter is one bit wider than the address so a full-RAM image never wraps.
    assign last_word  = ((COUNT_WIDTH + 1)'(addr_q) == (COUNT_WIDTH + 1)'(count_q) - 17'd1);

    // State, address counter, word count, checksum and word latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            run_q   <= 1'b0;
            addr_q  <= '0;
            count_q <= '0;
            chk_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            addr_q  <= addr_d;
            count_q <= count_d;
            chk_q   <= chk_d;
            data_q  <= data_d;
        end
    end

    // Next-state and datapath updates; only accepted bytes advance, WRITE/DONE self-advance.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        chk_d   = chk_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle, StError: begin
                if (accept && is_sync) begin
                    state_d = StCntHi;
                    addr_d  = '0;
                    chk_d   = '0;
                end
            end
            StCntHi: begin
                if (accept) begin
                    count_d[COUNT_WIDTH-1:BYTE_WIDTH] = bus.rx_data;
                    state_d = StCntLo;
                end
            end
            StCntLo: begin
                if (accept) begin
                    count_d = count_full;
                    state_d = count_valid(count_full, ADDR_WIDTH) ? StDataHi : StError;
                end
            end
            StDataHi: begin
                if (accept) begin
                    data_d[WORD_HI_LSB +: BYTE_WIDTH] = bus.rx_data;
                    chk_d   = chk_q ^ bus.rx_data;
                    state_d = StDataLo;
                end
            end
            StDataLo: begin
                if (accept) begin
                    data_d[WORD_LO_LSB +: BYTE_WIDTH] = bus.rx_data;
                    chk_d   = chk_q ^ bus.rx_data;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (last_word) begin
                    state_d = StCheck;
                end else begin
                    addr_d  = addr_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                    state_d = StDataHi;
                end
            end
            StCheck: begin
                if (accept) begin
                    state_d = (bus.rx_data == chk_q) ? StDone : StError;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from the current state; address/data hold between writes.
    always_comb begin
        ready            = run_q && (state_q != StWrite) && (state_q != StDone);
        bus.rx_ready     = ready;
        bus.prog_write   = (state_q == StWrite);
        bus.prog_address = addr_q[ADDR_WIDTH-1:0];
        bus.prog_data    = data_q;
        bus.cpu_hold     = (state_q != StIdle) && (state_q != StDone);
        bus.load_done    = (state_q == StDone);
        bus.load_error   = (state_q == StError);
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: a frame-level model predicts the RAM
// writes and the completion event of each frame; a monitor compares what the DUT presents.
module tb_program_loader;

    localparam int unsigned AW = 12;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    program_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(16)) bus ();

    program_loader #(
        .ADDR_WIDTH       (AW),
        .INSTRUCTION_WIDTH(4),
        .DATA_WIDTH       (16),
        .SYNC_BYTE        (8'hA5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Expected writes {addr[11:0], data[15:0]} and frame events (1 = done, 2 = error).
    logic [27:0] exp_wr_q[$];
    int          exp_ev_q[$];
    bit          ready_chk_en = 1'b0;
    logic        err_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: consume scoreboard entries whenever the DUT writes or finishes a frame.
    always @(negedge clk) begin
        logic [27:0] e;
        int          ev;
        if (reset) begin
            if (ready_chk_en)
                check("rx_ready_vs_write_done", bus.rx_ready, !(bus.prog_write || bus.load_done));
            if (bus.prog_write) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                             bus.prog_address, bus.prog_data);
                end else begin
                    e = exp_wr_q.pop_front();
                    check("write_addr", bus.prog_address, e[27:16]);
                    check("write_data", bus.prog_data, e[15:0]);
                    check("write_hold", bus.cpu_hold, 1);
                end
            end
            if (bus.load_done || (bus.load_error && !err_prev)) begin
                ev = bus.load_done ? 1 : 2;
                if (exp_ev_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got %0d, none expected", ev);
                end else begin
                    check("frame_event", ev, exp_ev_q.pop_front());
                end
                if (bus.load_done) check("done_releases_hold", bus.cpu_hold, 0);
            end
        end
        err_prev = bus.load_error;
    end

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int   t;
        logic ok;
        if (gap_max > 0) begin
            bus.rx_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        t = 0;
        do begin
            ok = bus.rx_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 200);
        bus.rx_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL rx_handshake: byte %0h not accepted within 200 cycles", b);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_wr_q.size() != 0 || exp_ev_q.size() != 0) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("scoreboard_drained", exp_wr_q.size() + exp_ev_q.size(), 0);
    endtask

    // chk_sel < 0 sends the correct checksum, otherwise chk_sel[7:0] is sent as CHK.
    task automatic send_frame(input logic [15:0] n, input logic [15:0] words[$],
                              input int chk_sel, input int gap_max);
        logic [7:0] chk;
        logic [7:0] chk_byte;
        bit         ok;
        chk = 8'h00;
        foreach (words[i]) chk = chk ^ words[i][15:8] ^ words[i][7:0];
        chk_byte = (chk_sel < 0) ? chk : 8'(chk_sel);
        ok = 1'b0;
        if (n == 0 || n > 16'd4096) begin
            exp_ev_q.push_back(2);
            send_byte(8'hA5, gap_max);
            send_byte(n[15:8], gap_max);
            send_byte(n[7:0], gap_max);
            check("count_error_flag", bus.load_error, 1);
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                logic [11:0] a;
                a = 12'(i);
                exp_wr_q.push_back({a, words[i]});
            end
            ok = (chk_byte == chk);
            exp_ev_q.push_back(ok ? 1 : 2);
            send_byte(8'hA5, gap_max);
            check("sync_clears_error", bus.load_error, 0);
            check("sync_sets_hold", bus.cpu_hold, 1);
            send_byte(n[15:8], gap_max);
            send_byte(n[7:0], gap_max);
            for (int i = 0; i < int'(n); i++) begin
                send_byte(words[i][15:8], gap_max);
                send_byte(words[i][7:0], gap_max);
                if (i == int'(n) - 1) check("write_latency", bus.prog_write, 1);
            end
            send_byte(chk_byte, gap_max);
            check("done_latency", bus.load_done, ok);
            check("error_latency", bus.load_error, !ok);
        end
        wait_drain();
        check("hold_after_frame", bus.cpu_hold, !ok);
    endtask

    initial begin
        logic [15:0] w[$];
        logic [15:0] empty[$];
        logic [15:0] n;
        int          pos;

        reset        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #22;
        check("reset_rx_ready", bus.rx_ready, 0);
        check("reset_prog_write", bus.prog_write, 0);
        check("reset_prog_address", bus.prog_address, 0);
        check("reset_prog_data", bus.prog_data, 0);
        check("reset_cpu_hold", bus.cpu_hold, 0);
        check("reset_load_done", bus.load_done, 0);
        check("reset_load_error", bus.load_error, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", bus.rx_ready, 1);
        ready_chk_en = 1'b1;

        // Stray bytes in IDLE are dropped, then the reference frame (81^23^45^67 = 80).
        send_byte(8'h12, 0);
        send_byte(8'h00, 1);
        w = '{16'h8123, 16'h4567};
        send_frame(16'd2, w, 8'h80, 0);

        // Same frame with a zero checksum: words still written, frame rejected.
        send_frame(16'd2, w, 8'h00, 0);
        // Bytes in ERROR are dropped; the held core stays held.
        send_byte(8'h11, 0);
        send_byte(8'h5A, 2);
        check("error_sticky", bus.load_error, 1);
        check("error_hold", bus.cpu_hold, 1);

        // Count boundaries: zero and one past the RAM size.
        send_frame(16'd0, empty, -1, 0);
        send_frame(16'h1001, empty, -1, 1);

        // Recovery from ERROR with a valid frame.
        w = '{16'hA5A5, 16'h0001, 16'hFFFF};
        send_frame(16'd3, w, -1, 0);

        // Random frames with gaps and an embedded SYNC-valued data byte.
        for (int f = 0; f < 8; f++) begin
            n = 16'($urandom_range(1, 8));
            w = {};
            for (int i = 0; i < int'(n); i++) w.push_back(16'($urandom));
            pos = $urandom_range(0, int'(n) - 1);
            if ($urandom_range(0, 1) == 0) w[pos][15:8] = 8'hA5;
            else w[pos][7:0] = 8'hA5;
            send_frame(n, w, ($urandom_range(0, 3) == 0) ? 8'($urandom) : -1, 3);
        end

        // Asynchronous reset while the second data byte is being offered.
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h81, 0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h23;
        #2;
        ready_chk_en = 1'b0;
        reset        = 1'b0;
        #1;
        check("midreset_rx_ready", bus.rx_ready, 0);
        check("midreset_prog_write", bus.prog_write, 0);
        check("midreset_prog_address", bus.prog_address, 0);
        check("midreset_prog_data", bus.prog_data, 0);
        check("midreset_cpu_hold", bus.cpu_hold, 0);
        check("midreset_load_done", bus.load_done, 0);
        check("midreset_load_error", bus.load_error, 0);
        bus.rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_midreset", bus.rx_ready, 1);
        ready_chk_en = 1'b1;
        w = '{16'h8123, 16'h4567, 16'h0F0F};
        send_frame(16'd3, w, -1, 2);

        // Full RAM image: the last write lands at address FFF without wrapping.
        w = {};
        for (int i = 0; i < 4096; i++) w.push_back(16'($urandom));
        send_frame(16'd4096, w, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
